// File: rtl/bit_stuffer_param.sv
// bit_stuffer_param
// Inserts one STUFF_VAL bit into a serial transmit stream after every run of
// RUN_LEN consecutive ~STUFF_VAL bits. It sits between an upstream shifter
// and the line driver. While a stuffed bit is owed, the upstream data bit is
// held (shift_en low) for exactly one bit time.
//
// Parameters
//   RUN_LEN   : run length that triggers a stuffed bit (2..15)
//   STUFF_VAL : value of the inserted bit; the run bit is ~STUFF_VAL
//   CNT_W     : width of the saturating stuffed-bit counter (1..16)
//
// Ports
//   clk          : clock, rising edge
//   n_rst        : asynchronous active-low reset
//   serial_in    : current unstuffed data bit
//   shift_strobe : one-cycle bit-time strobe
//   clear        : synchronous packet-start restart
//   stuff_bypass : pass data without stuffing (SYNC/EOP fields)
//   bit_out      : bit to transmit this bit time
//   shift_en     : upstream may advance to its next data bit
//   stuff_active : a stuffed bit is pending / being emitted
//   stuff_total  : saturating count of stuffed bits emitted
module bit_stuffer_param #(
    parameter int   RUN_LEN   = 6,
    parameter logic STUFF_VAL = 1'b0,
    parameter int   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             serial_in,
    input  logic             shift_strobe,
    input  logic             clear,
    input  logic             stuff_bypass,
    output logic             bit_out,
    output logic             shift_en,
    output logic             stuff_active,
    output logic [CNT_W-1:0] stuff_total
);

    localparam int            RC_W     = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0] RUN_LAST = RC_W'(RUN_LEN - 1);
    localparam logic          RUN_BIT  = ~STUFF_VAL;

    logic [RC_W-1:0] run_cnt;
    logic            pending;

    // Outputs are purely combinational from state and inputs: the stuffed
    // bit is shown in the same bit time its strobe consumes.
    assign bit_out      = pending ? STUFF_VAL : serial_in;
    assign shift_en     = shift_strobe & ~pending;
    assign stuff_active = pending;

    // Priority: clear, then an owed stuffed bit (even inside a bypassed
    // field, so a run ending on the last data bit is still completed),
    // then bypass, then normal run counting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run_cnt     <= '0;
            pending     <= 1'b0;
            stuff_total <= '0;
        end else if (clear) begin
            run_cnt     <= '0;
            pending     <= 1'b0;
            stuff_total <= '0;
        end else if (shift_strobe) begin
            if (pending) begin
                pending <= 1'b0;
                run_cnt <= '0;
                if (stuff_total != {CNT_W{1'b1}})
                    stuff_total <= stuff_total + CNT_W'(1);
            end else if (stuff_bypass) begin
                run_cnt <= '0;
            end else if (serial_in == RUN_BIT) begin
                // Counter tops out at RUN_LEN-1; the RUN_LEN-th run bit
                // arms the stuffed bit instead of counting further.
                if (run_cnt == RUN_LAST) begin
                    pending <= 1'b1;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + RC_W'(1);
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bit_stuffer_param.sv
// Testbench for bit_stuffer_param. Three instances cover the default
// configuration, RUN_LEN=3/STUFF_VAL=1, and a 2-bit saturating counter.
// Expected outputs are pushed onto a scoreboard queue as each step is driven
// and popped and compared mid-cycle.
module tb_bit_stuffer_param;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic sin [3];
    logic stb [3];
    logic clr [3];
    logic byp [3];
    logic bo  [3];
    logic se  [3];
    logic sa  [3];
    logic [7:0] tot0, tot1;
    logic [1:0] tot2;

    bit_stuffer_param u_d0 (
        .clk(clk), .n_rst(n_rst), .serial_in(sin[0]), .shift_strobe(stb[0]),
        .clear(clr[0]), .stuff_bypass(byp[0]), .bit_out(bo[0]),
        .shift_en(se[0]), .stuff_active(sa[0]), .stuff_total(tot0));

    bit_stuffer_param #(.RUN_LEN(3), .STUFF_VAL(1'b1)) u_d1 (
        .clk(clk), .n_rst(n_rst), .serial_in(sin[1]), .shift_strobe(stb[1]),
        .clear(clr[1]), .stuff_bypass(byp[1]), .bit_out(bo[1]),
        .shift_en(se[1]), .stuff_active(sa[1]), .stuff_total(tot1));

    bit_stuffer_param #(.CNT_W(2)) u_d2 (
        .clk(clk), .n_rst(n_rst), .serial_in(sin[2]), .shift_strobe(stb[2]),
        .clear(clr[2]), .stuff_bypass(byp[2]), .bit_out(bo[2]),
        .shift_en(se[2]), .stuff_active(sa[2]), .stuff_total(tot2));

    typedef struct packed {
        logic        b;
        logic        s;
        logic        a;
        logic [15:0] t;
    } exp_t;

    exp_t sbq[$];
    int   vecs = 0;
    int   errs = 0;

    function automatic exp_t observe(input int d);
        exp_t o;
        o.b = bo[d];
        o.s = se[d];
        o.a = sa[d];
        o.t = (d == 0) ? 16'(tot0) : (d == 1) ? 16'(tot1) : 16'(tot2);
        return o;
    endfunction

    task automatic push(input logic eb, input logic es, input logic ea, input int et);
        exp_t e;
        e.b = eb;
        e.s = es;
        e.a = ea;
        e.t = 16'(et);
        sbq.push_back(e);
    endtask

    task automatic check(input int d, input string tag);
        exp_t e;
        exp_t o;
        if (sbq.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sbq.pop_front();
        o = observe(d);
        vecs += 4;
        assert (o.b === e.b) else begin
            errs++;
            $error("FAIL %s bit_out obs=%b exp=%b", tag, o.b, e.b);
        end
        assert (o.s === e.s) else begin
            errs++;
            $error("FAIL %s shift_en obs=%b exp=%b", tag, o.s, e.s);
        end
        assert (o.a === e.a) else begin
            errs++;
            $error("FAIL %s stuff_active obs=%b exp=%b", tag, o.a, e.a);
        end
        assert (o.t === e.t) else begin
            errs++;
            $error("FAIL %s stuff_total obs=%0d exp=%0d", tag, o.t, e.t);
        end
    endtask

    task automatic drive(input int d, input logic si, input logic st,
                         input logic by, input logic cl);
        for (int i = 0; i < 3; i++) begin
            sin[i] = 1'b0;
            stb[i] = 1'b0;
            clr[i] = 1'b0;
            byp[i] = 1'b0;
        end
        sin[d] = si;
        stb[d] = st;
        byp[d] = by;
        clr[d] = cl;
    endtask

    // One bit time: drive at posedge+1, expect, compare at negedge.
    // et is the stuff_total value before this cycle's edge.
    task automatic step(input string tag, input int d, input logic si,
                        input logic st, input logic by, input logic cl,
                        input logic eb, input logic es, input logic ea,
                        input int et);
        drive(d, si, st, by, cl);
        push(eb, es, ea, et);
        @(negedge clk);
        check(d, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state: pass-through, no stuffing.
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 0);
        @(negedge clk);
        check(0, "reset_d0");
        drive(1, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 0);
        #1;
        check(1, "reset_d1");
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Six run bits, then the stuffed 0 on the seventh strobe.
        for (int i = 0; i < 6; i++)
            step("run6_data", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step("run6_stuff", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step("run6_idle", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);

        // Clear with a strobe zeroes the total.
        step("clr_strobe", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1);

        // 1,1,1,1,1,0,1,1,1,1,1,1: the 0 breaks the first run.
        begin
            logic [11:0] pat;
            pat = 12'b111110111111;
            for (int i = 11; i >= 0; i--)
                step("pat_data", 0, pat[i], 1'b1, 1'b0, 1'b0, pat[i], 1'b1, 1'b0, 0);
        end
        step("pat_stuff", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step("pat_next", 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);

        // Run ending on last data bit, then bypassed field.
        step("clr_idle", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 6; i++)
            step("byp_data", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step("byp_stuff", 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 7; i++)
            step("byp_ones", 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        step("byp_hold", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);

        // Reset while a stuffed bit is pending discards it.
        step("rst_clr", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 6; i++)
            step("rst_data", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, 0);
        #1;
        check(0, "rst_pending");
        n_rst = 1'b0;
        push(1'b1, 1'b0, 1'b0, 0);
        #1;
        check(0, "rst_async");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        step("rst_after", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step("rst_after2", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // RUN_LEN=3, STUFF_VAL=1: nine zeros need twelve strobes.
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 3; i++)
                step("r3_data", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, g);
            step("r3_stuff", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, g);
        end
        step("r3_total", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

        // CNT_W=2: five stuffing events saturate at 3.
        for (int e = 0; e < 5; e++) begin
            for (int i = 0; i < 6; i++)
                step("sat_data", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, (e > 3) ? 3 : e);
            step("sat_stuff", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (e > 3) ? 3 : e);
        end
        step("sat_stick", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        // Partial run, then clear with strobe must also zero the run counter.
        for (int i = 0; i < 3; i++)
            step("sat_part", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        step("sat_clr", 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3);
        step("sat_zero", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++)
            step("sat_rerun", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step("sat_restuff", 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step("sat_one", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
